// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// sign handled by magnitude operands plus a final conditional negate.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic [1:0]         op_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic               stallreq_o,
  output logic [2*WIDTH-1:0] result_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // BUSY   | one radix-2 step per cycle, WIDTH steps
  // DONE   | result presented, ready pulses
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               neg_q, neg_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               start_ok, div_zero;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quot, remd;
  logic [2*WIDTH-1:0] prod, fin;

  assign abs_a    = (op_i[0] & opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b    = (op_i[0] & opb_i[WIDTH-1]) ? -opb_i : opb_i;
  assign start_ok = start_i & ~annul_i;
  assign div_zero = op_i[1] & (opb_i == '0);

  // Accumulator holds {partial sum, remaining multiplier bits}; the sum keeps its carry.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign div_trial = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = rem_q[WIDTH] | (div_trial >= {1'b0, b_q});

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -quo_q : quo_q;
  assign remd = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign fin  = dz_q ? {a_q, {WIDTH{1'b1}}} : (is_div_q ? {remd, quot} : prod);

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          is_div_d = op_i[1];
          dz_d     = div_zero;
          neg_d    = op_i[0] & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          neg_r_d  = op_i[0] & opa_i[WIDTH-1];
          a_d      = div_zero ? opa_i : abs_a;
          b_d      = abs_b;
          quo_d    = abs_a;
          rem_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, abs_b};
          cnt_d    = '0;
          state_d  = div_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            quo_d = {quo_q[WIDTH-2:0], div_ge};
            rem_d = div_ge ? div_diff : div_trial;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!annul_i) result_d = fin;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o     = (state_q == S_BUSY);
  assign ready_o    = (state_q == S_DONE) & ~annul_i;
  assign stallreq_o = ((state_q == S_IDLE) & start_ok) | busy_o;
  // An annulled DONE never exposes the new value.
  assign result_o   = ready_o ? fin : result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: 32-bit and 8-bit instances, directed cases plus random
// operations compared with an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  op32, op8;
  logic        start32, start8, annul32, annul8;
  logic [31:0] opa32, opb32;
  logic [7:0]  opa8, opb8;
  logic        busy32, ready32, stall32, busy8, ready8, stall8;
  logic [63:0] result32;
  logic [15:0] result8;

  int checks = 0;
  int errors = 0;
  bit use8 = 1'b0;

  localparam logic [1:0] OP_MULU = 2'b00, OP_MUL = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .resetn_i(resetn), .op_i(op32), .start_i(start32), .annul_i(annul32),
    .opa_i(opa32), .opb_i(opb32), .busy_o(busy32), .ready_o(ready32),
    .stallreq_o(stall32), .result_o(result32)
  );

  mdu_iter #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .resetn_i(resetn), .op_i(op8), .start_i(start8), .annul_i(annul8),
    .opa_i(opa8), .opb_i(opb8), .busy_o(busy8), .ready_o(ready8),
    .stallreq_o(stall8), .result_o(result8)
  );

  logic        r_ready, r_busy, r_stall;
  logic [63:0] r_result;
  assign r_ready  = use8 ? ready8 : ready32;
  assign r_busy   = use8 ? busy8 : busy32;
  assign r_stall  = use8 ? stall8 : stall32;
  assign r_result = use8 ? {48'd0, result8} : result32;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input int w, input logic [1:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m1, m2, a, b;
    longint sa, sb, q, r;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    a  = a_in & m1;
    b  = b_in & m1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (!op[1]) begin
      if (op[0]) return 64'(sa * sb) & m2;
      return (a * b) & m2;
    end
    if (b == 0) return ((a << w) | m1) & m2;
    if (!op[0]) return ((a % b) << w) | (a / b);
    if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      q = longint'(1) << (w - 1);
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return ((64'(r) & m1) << w) | (64'(q) & m1);
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'($urandom_range(0, 20));
      default: return {32'($urandom), 32'($urandom)} & m;
    endcase
  endfunction

  // Launch one operation; lat counts cycles from the start cycle (0) to ready.
  task automatic run(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                     output logic [63:0] res, output int lat, output int stall_bad,
                     output bit saw_busy);
    stall_bad = 0;
    saw_busy  = 1'b0;
    res       = '0;
    @(negedge clk);
    if (use8) begin op8 = op; opa8 = a[7:0]; opb8 = b[7:0]; start8 = 1'b1; end
    else begin op32 = op; opa32 = a[31:0]; opb32 = b[31:0]; start32 = 1'b1; end
    #1;
    if (!r_stall) stall_bad++;
    @(posedge clk); #1;
    if (use8) begin start8 = 1'b0; op8 = 2'($urandom); opa8 = 8'($urandom); opb8 = 8'($urandom); end
    else begin start32 = 1'b0; op32 = 2'($urandom); opa32 = $urandom; opb32 = $urandom; end
    lat = 1;
    while (!r_ready && lat < 100) begin
      if (!r_stall) stall_bad++;
      if (r_busy) saw_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (r_ready) begin
      res = r_result;
      if (r_stall) stall_bad++;
    end
    @(posedge clk); #1;
  endtask

  logic [63:0] res, a, b, prev;
  logic [1:0]  op;
  int lat, sb, exp_lat;
  bit sbusy;

  initial begin
    resetn = 1'b0;
    op32 = '0; op8 = '0; start32 = 1'b0; start8 = 1'b0; annul32 = 1'b0; annul8 = 1'b0;
    opa32 = '0; opb32 = '0; opa8 = '0; opb8 = '0;
    #12;
    chk("rst_busy",   {62'd0, busy32, busy8},   64'd0);
    chk("rst_ready",  {62'd0, ready32, ready8}, 64'd0);
    chk("rst_stall",  {62'd0, stall32, stall8}, 64'd0);
    chk("rst_result", result32 | {48'd0, result8}, 64'd0);
    @(negedge clk); resetn = 1'b1;

    run(OP_DIVU, 64'd100, 64'd7, res, lat, sb, sbusy);
    chk("divu_res", res, {32'd2, 32'd14});
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_stall", 64'(sb), 64'd0);
    run(OP_DIV, 64'hFFFF_FFF9, 64'd2, res, lat, sb, sbusy);
    chk("div_neg", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run(OP_MULU, 64'hFFFF_FFFF, 64'd2, res, lat, sb, sbusy);
    chk("multu", res, 64'h0000_0001_FFFF_FFFE);
    run(OP_DIV, 64'd9, 64'd0, res, lat, sb, sbusy);
    chk("dz_res", res, {32'd9, 32'hFFFF_FFFF});
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_busy", 64'(sbusy), 64'd0);
    run(OP_MUL, 64'hFFFF_FFFD, 64'd5, res, lat, sb, sbusy);
    chk("mult_neg", res, 64'hFFFF_FFFF_FFFF_FFF1);
    prev = res;

    // annul in BUSY cycle 10
    @(negedge clk); op32 = OP_DIVU; opa32 = 32'd1000; opb32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1; annul32 = 1'b1;
    #1; chk("annul_busy_rdy", {63'd0, ready32}, 64'd0);
    @(posedge clk); #1; annul32 = 1'b0;
    chk("annul_busy_st", {62'd0, busy32, stall32}, 64'd0);
    chk("annul_busy_res", result32, prev);
    repeat (40) begin
      @(posedge clk); #1;
      if (ready32) chk("annul_no_rdy", {63'd0, ready32}, 64'd0);
    end
    run(OP_DIVU, 64'd100, 64'd7, res, lat, sb, sbusy);
    chk("divu_after_annul", res, {32'd2, 32'd14});
    prev = res;

    // annul in the DONE cycle
    @(negedge clk); op32 = OP_MULU; opa32 = 32'd6; opb32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (32) @(posedge clk);
    #1; annul32 = 1'b1;
    #1; chk("annul_done_rdy", {63'd0, ready32}, 64'd0);
    chk("annul_done_res0", result32, prev);
    @(posedge clk); #1; annul32 = 1'b0;
    chk("annul_done_res1", result32, prev);
    chk("annul_done_busy", {63'd0, busy32}, 64'd0);

    // annul overrides start in IDLE
    @(negedge clk); op32 = OP_MULU; start32 = 1'b1; annul32 = 1'b1;
    #1; chk("annul_idle_stall", {63'd0, stall32}, 64'd0);
    @(posedge clk); #1;
    chk("annul_idle_busy", {63'd0, busy32}, 64'd0);
    start32 = 1'b0; annul32 = 1'b0;

    // asynchronous reset mid-operation
    @(negedge clk); op32 = OP_DIVU; opa32 = 32'd100; opb32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (4) @(posedge clk);
    #2; resetn = 1'b0;
    #1;
    chk("arst_flags", {61'd0, busy32, ready32, stall32}, 64'd0);
    chk("arst_result", result32, 64'd0);
    @(negedge clk); resetn = 1'b1;
    run(OP_DIVU, 64'd100, 64'd7, res, lat, sb, sbusy);
    chk("divu_after_rst", res, {32'd2, 32'd14});

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = pick(32);
      b  = pick(32);
      exp_lat = (op[1] && b[31:0] == 0) ? 1 : 33;
      run(op, a, b, res, lat, sb, sbusy);
      chk($sformatf("rnd32_res op%0d %h %h", op, a[31:0], b[31:0]), res, ref_model(32, op, a, b));
      chk("rnd32_lat", 64'(lat), 64'(exp_lat));
      chk("rnd32_stall", 64'(sb), 64'd0);
    end

    use8 = 1'b1;
    run(OP_DIV, 64'h80, 64'hFF, res, lat, sb, sbusy);
    chk("w8_div_min", res, 64'h0080);
    chk("w8_div_lat", 64'(lat), 64'd9);
    run(OP_MULU, 64'hFF, 64'hFF, res, lat, sb, sbusy);
    chk("w8_multu", res, 64'hFE01);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = pick(8);
      b  = pick(8);
      exp_lat = (op[1] && b[7:0] == 0) ? 1 : 9;
      run(op, a, b, res, lat, sb, sbusy);
      chk($sformatf("rnd8_res op%0d %h %h", op, a[7:0], b[7:0]), res, ref_model(8, op, a, b));
      chk("rnd8_lat", 64'(lat), 64'(exp_lat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the EX stage. Executes signed and unsigned multiply and divide over `WIDTH`-bit operands with a start/ready/annul handshake. It raises a stall request that holds the pipeline until the result is delivered. It replaces the fixed 32-bit divider plus separate multiplier with one shared, width-generic sequential datapath.

## Interface
- `WIDTH`, default 32: operand width; results are `2*WIDTH` bits; must be ≥ 4.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `op` in 2: operation select.
  - `op[1]`: 1 = divide, 0 = multiply.
  - `op[0]`: 1 = signed, 0 = unsigned.
- `start` in 1: request an operation; sampled only in IDLE.
- `annul` in 1: abort the current operation.
- `opa` in WIDTH: multiplicand or dividend; sampled only in the start cycle.
- `opb` in WIDTH: multiplier or divisor; sampled only in the start cycle.
- `busy` out 1: high in BUSY.
- `ready` out 1: high for exactly one cycle in DONE.
- `stallreq` out 1: combinational; `(IDLE & start & ~annul) | BUSY`.
- `result` out 2*WIDTH: `{hi, lo}`.
  - Multiply: full product.
  - Divide: hi = remainder, lo = quotient.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `start & ~annul` latches `op`, |opa| and |opb|, computes the result sign flags, and clears the step counter.
  - Next state is BUSY, or DONE directly if the operation is a divide and `opb == 0`.
- BUSY: one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After step `WIDTH` completes, next state is DONE.
- DONE:
  - `ready` = 1, `result` updated this cycle.
  - Unconditionally returns to IDLE.
- Sign handling (signed ops; unsigned ops apply no correction):
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
- Signed divide of the most-negative value by −1: quotient wraps to `2^(WIDTH-1)`, remainder 0; no exception.
- Divide by zero (any signedness): hi = `opa` unmodified, lo = all ones; one-cycle path IDLE→DONE.
- `result` holds its last value until the next DONE; it is not cleared at start.
- `annul`:
  - In BUSY or DONE: next state is IDLE, `ready` is suppressed in that cycle, and `result` is unchanged.
  - In IDLE: `annul` overrides `start`.
- `start` still high in the cycle after DONE (back in IDLE) begins a new operation. The requester must drop `start` once it sees `ready`.
- Changes on `op`, `opa` or `opb` after the start cycle have no effect.

## Timing
- Reset (`resetn` low, asynchronous) forces:
  - state IDLE;
  - `busy` = 0, `ready` = 0, `result` = 0, `stallreq` = 0;
  - counter and internal registers = 0.
- Reset mid-operation abandons the operation immediately.
- Normal latency, with the start accepted at cycle 0:
  - BUSY in cycles 1..WIDTH;
  - `ready` and valid `result` in cycle WIDTH+1;
  - earliest next start in cycle WIDTH+2.
- Divide-by-zero latency: `ready` in cycle 1.
- `stallreq` is high from cycle 0 through cycle WIDTH and low in the DONE cycle, so the pipeline advances on the edge that ends DONE.
- `annul` takes effect on the next edge; `stallreq` drops in the cycle after `annul` is sampled.
- Arithmetic:
  - Internal remainder register is `WIDTH+1` bits.
  - Product accumulator is `2*WIDTH` bits.
  - Counter width is `$clog2(WIDTH+1)`.
  - Negation is two's complement, modulo the field width.

## Test plan
- **divu, WIDTH=32:** opa=100, opb=7 -> `ready` in cycle 33, hi=2, lo=14; `stallreq` high in cycles 0–32, low in cycle 33.
- **div, WIDTH=32:** opa=−7 (0xFFFFFFF9), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Multiply, WIDTH=32:**
  - mult −3×5 -> result 0xFFFFFFFF_FFFFFFF1.
  - multu 0xFFFFFFFF×2 -> result 0x00000001_FFFFFFFE.
- **Divide by zero:** div 9/0 -> `ready` in cycle 1, hi=9, lo=0xFFFFFFFF, `busy` never high.
- **Annul and reset:**
  - `annul` in BUSY cycle 10 -> no `ready` pulse, IDLE next cycle, `result` keeps its previous value; a following divu 100/7 still gives 14 r 2.
  - `resetn` low in BUSY cycle 5 -> all outputs 0 immediately, without waiting for a clock edge.
- **WIDTH=8 instance:**
  - div 0x80/0xFF -> `ready` in cycle 9, lo=0x80, hi=0x00.
  - multu 0xFF×0xFF -> 0xFE01.
